rom_fetch_port: RTL and testbench
=================================

Name: rom_fetch_port

Overview:
- Instruction-fetch front end between the CPU instruction bus and the 1024x32 boot ROM.
- Accepts byte-addressed fetch commands over a valid/ready handshake and drives the ROM word address.
- Captures the ROM's 1-cycle registered read data and returns it in order over a valid/ready response channel, with an error flag.
- Buffers up to FIFO_DEPTH responses so the CPU can stall without losing fetched words.

Parameters:
- ADDR_WIDTH, 10, ROM word-address width; window is 4*2**ADDR_WIDTH bytes.
- DATA_WIDTH, 32, instruction word width.
- BASE_ADDR, 32'h0000_0000, byte base address of the ROM window; must be aligned to the window size.
- FIFO_DEPTH, 3, maximum outstanding commands (accepted but not yet popped).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- cmd_valid_i  in  1  fetch request valid.
- cmd_ready_o  out  1  fetch request accepted when high with cmd_valid_i.
- cmd_addr_i  in  32  fetch byte address.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
- rsp_data_o  out  DATA_WIDTH  fetched word.
- rsp_error_o  out  1  response belongs to a faulting fetch.
- rom_addr_o  out  ADDR_WIDTH  ROM word address; connects to the ROM's addr_i.
- rom_q_i  in  DATA_WIDTH  ROM registered read data; connects to the ROM's q_o.

Behaviour:
- Reset: rst_i is asynchronous and active-high, and reset is complete immediately.
  - Outstanding counter = 0, pending flag = 0, FIFO empty.
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_error_o = 0.
  - Reset asserted mid-operation discards all in-flight and buffered responses. No response appears after deassertion unless a new command is issued.
- Accept: occurs when cmd_valid_i && cmd_ready_o.
  - cmd_ready_o = (outstanding < FIFO_DEPTH) && !rst_i.
  - cmd_ready_o is combinational from registered state only; it has no path from rsp_ready_i or cmd_valid_i.
- rom_addr_o = cmd_addr_i[ADDR_WIDTH+1:2] (word index), combinational.
- Fault check, evaluated in the accept cycle:
  - Fault if cmd_addr_i[1:0] != 0.
  - Fault if cmd_addr_i is outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH).
  - A faulting command still occupies a slot and returns in order with rsp_error_o=1 and rsp_data_o=0. rom_q_i is ignored for it.
- Pipeline:
  - Accept in cycle N sets the pending flag and a registered fault bit for cycle N+1.
  - In cycle N+1, rom_q_i (or 0 if faulting) and the fault bit are written into the FIFO tail.
  - The FIFO head is visible from cycle N+2: rsp_valid_o = FIFO non-empty (registered).
  - Latency from accept to rsp_valid_o is exactly 2 cycles when the FIFO is empty.
- Outstanding counter:
  - +1 on accept, -1 on response pop, unchanged when both occur in the same cycle.
  - Range 0..FIFO_DEPTH; it never overflows because of cmd_ready_o gating.
- Response handshake:
  - While rsp_valid_o && !rsp_ready_i, rsp_data_o and rsp_error_o hold stable.
  - A pop and a FIFO write in the same cycle are both honoured.
  - When the FIFO is empty, rsp_data_o and rsp_error_o hold their last popped values. They are not required to be zero.
- Throughput: back-to-back accepts every cycle sustain 1 response/cycle when rsp_ready_i is held high (FIFO_DEPTH >= 3 is required for this).
- Ordering: responses are strictly in command order.

Test Plan:
- Single fetch:
  - Stimulus: ROM word 5 = 32'hDEADBEEF; cmd_addr=BASE+0x14 accepted at cycle 10, rsp_ready_i=1.
  - Required: rsp_valid_o=1 only in cycle 12 with data DEADBEEF and error=0; cmd_ready_o=1 throughout.
- Streaming:
  - Stimulus: accept addresses BASE+0x0, +0x4, ... +0x1C on 8 consecutive cycles with rsp_ready_i=1.
  - Required: 8 consecutive rsp_valid cycles starting 2 cycles after the first accept, data equal to ROM words 0..7 in order; cmd_ready_o never drops.
- Backpressure:
  - Stimulus: rsp_ready_i=0 while issuing commands every cycle.
  - Required: exactly 3 accepts, then cmd_ready_o=0; rsp_data_o stays equal to word 0 while stalled.
  - Then raise rsp_ready_i: words 0, 1, 2 pop on successive cycles, and cmd_ready_o reasserts in the cycle after the first pop.
- Faults:
  - Stimulus: commands at BASE+0x2 (misaligned), BASE+0x1000 (one past the window), then BASE+0xFFC.
  - Required: responses in order (error=1, data=0), (error=1, data=0), (error=0, data=ROM word 1023).
- Reset mid-operation:
  - Stimulus: rsp_ready_i=0, 2 commands outstanding; pulse rst_i asynchronously between clock edges.
  - Required: rsp_valid_o=0 immediately; after deassertion no stale responses appear, cmd_ready_o=1, and the next fetch returns correct data with 2-cycle latency.

Source files
------------

// File: rtl/rom_fetch_port.sv
// Instruction-fetch front end for the boot ROM: accepts byte-addressed fetches,
// drives the ROM word address and returns the registered read data in order.
module rom_fetch_port #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [31:0]           cmd_addr_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_error_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i
);

  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int WIN_LSB = ADDR_WIDTH + 2;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);

  logic [CW-1:0]         outstanding_q;
  logic [CW-1:0]         fill_q;
  logic                  pending_q;
  logic                  fault_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic                  err_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] last_data_q;
  logic                  last_err_q;

  logic accept;
  logic pop;
  logic fault;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PW'(1);
  endfunction

  assign cmd_ready_o = (outstanding_q < DEPTH_C) && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign rsp_valid_o = (fill_q != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign rom_addr_o  = cmd_addr_i[ADDR_WIDTH+1:2];

  // BASE_ADDR is window-aligned, so the range check reduces to the upper bits.
  assign fault = (cmd_addr_i[1:0] != 2'b00) ||
                 (cmd_addr_i[31:WIN_LSB] != BASE_ADDR[31:WIN_LSB]);

  // With the FIFO empty the last popped response stays on the outputs.
  assign rsp_data_o  = rsp_valid_o ? data_mem[rd_ptr_q] : last_data_q;
  assign rsp_error_o = rsp_valid_o ? err_mem[rd_ptr_q]  : last_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      pending_q     <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      pending_q <= accept;
      fault_q   <= accept && fault;
      case ({accept, pop})
        2'b10:   outstanding_q <= outstanding_q + CW'(1);
        2'b01:   outstanding_q <= outstanding_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_data_q <= '0;
      last_err_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        err_mem[i]  <= 1'b0;
      end
    end else begin
      if (pending_q) begin
        data_mem[wr_ptr_q] <= fault_q ? '0 : rom_q_i;
        err_mem[wr_ptr_q]  <= fault_q;
        wr_ptr_q           <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        last_data_q <= data_mem[rd_ptr_q];
        last_err_q  <= err_mem[rd_ptr_q];
        rd_ptr_q    <= next_ptr(rd_ptr_q);
      end
      case ({pending_q, pop})
        2'b10:   fill_q <= fill_q + CW'(1);
        2'b01:   fill_q <= fill_q - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetch_port.sv
// Bench for rom_fetch_port: ROM model plus a queue-based response reference,
// directed scenarios followed by randomized traffic.
module tb_rom_fetch_port;

  localparam logic [31:0] BASE  = 32'h0004_0000;
  localparam int          DEPTH = 3;

  typedef struct {
    logic        rdy;
    logic        vld;
    logic        err;
    logic [31:0] data;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [9:0]  rom_addr;
  logic [31:0] rom_q;

  logic [31:0] rom_mem [1024];
  exp_t        exp_q [$];
  logic [31:0] last_data;
  logic        last_err;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  rom_fetch_port #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(32),
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_addr_i (cmd_addr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_error_o(rsp_error),
    .rom_addr_o (rom_addr),
    .rom_q_i    (rom_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rom_q <= rom_mem[rom_addr];
  end

  function automatic logic ref_err(input logic [31:0] a);
    return (a % 4 != 0) || (a < BASE) || (a >= BASE + 32'h1000);
  endfunction

  function automatic logic [31:0] ref_data(input logic [31:0] a);
    logic [31:0] idx;
    idx = (a - BASE) / 4;
    return ref_err(a) ? 32'h0 : rom_mem[idx[9:0]];
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_data = 32'h0;
    last_err  = 1'b0;
  endtask

  // One clock cycle: drive, sample at negedge, predict, advance the reference.
  task automatic cycle(input logic v, input logic [31:0] a, input logic rr,
                       output obs_t o, output obs_t e);
    exp_t ent;
    cmd_valid = v;
    cmd_addr  = a;
    rsp_ready = rr;
    @(negedge clk);
    o.rdy  = cmd_ready;
    o.vld  = rsp_valid;
    o.err  = rsp_error;
    o.data = rsp_data;
    e.rdy  = (exp_q.size() < DEPTH);
    e.vld  = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
    e.data = e.vld ? exp_q[0].data : last_data;
    e.err  = e.vld ? exp_q[0].err  : last_err;
    if (e.vld && rr) begin
      last_data = exp_q[0].data;
      last_err  = exp_q[0].err;
      void'(exp_q.pop_front());
    end
    if (v && e.rdy) begin
      ent.data = ref_data(a);
      ent.err  = ref_err(a);
      ent.due  = cyc + 2;
      exp_q.push_back(ent);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 32'h0;
    rsp_ready = 1'b0;
    #3;
    checks += 4;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", cmd_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", rsp_data); end
    if (rsp_error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", rsp_error); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checks += 2;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", cmd_ready); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_release_valid got %b want 0", rsp_valid); end
  endtask

  task automatic test_single();
    obs_t o, e;
    int   vcount = 0;
    rom_mem[5] = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) begin
      cycle(i == 0, BASE + 32'h14, 1'b1, o, e);
      if (o.vld === 1'b1) vcount++;
      checks += 2;
      if (o.rdy !== 1'b1) begin errors++; $display("FAIL single_ready cyc %0d got %b want 1", i, o.rdy); end
      if (o.vld !== 1'(i == 2)) begin errors++; $display("FAIL single_valid cyc %0d got %b want %b", i, o.vld, i == 2); end
      if (i == 2) begin
        checks++;
        if (o.data !== 32'hDEADBEEF || o.err !== 1'b0)
          begin errors++; $display("FAIL single_data got %h/%b want deadbeef/0", o.data, o.err); end
      end
    end
    checks++;
    if (vcount != 1) begin errors++; $display("FAIL single_count got %0d want 1", vcount); end
  endtask

  task automatic test_stream();
    obs_t o, e;
    for (int i = 0; i < 12; i++) begin
      cycle(i < 8, BASE + 32'(4 * i), 1'b1, o, e);
      checks += 2;
      if (o.rdy !== 1'b1) begin errors++; $display("FAIL stream_ready cyc %0d got %b want 1", i, o.rdy); end
      if (o.vld !== 1'(i >= 2 && i < 10)) begin errors++; $display("FAIL stream_valid cyc %0d got %b", i, o.vld); end
      if (i >= 2 && i < 10) begin
        checks++;
        if (o.data !== rom_mem[i-2] || o.err !== 1'b0)
          begin errors++; $display("FAIL stream_data cyc %0d got %h/%b want %h/0", i, o.data, o.err, rom_mem[i-2]); end
      end
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    int   accepts = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, BASE + 32'(4 * i), 1'b0, o, e);
      if (o.rdy === 1'b1) accepts++;
      checks += 2;
      if (o.rdy !== 1'(i < 3)) begin errors++; $display("FAIL bp_ready cyc %0d got %b want %b", i, o.rdy, i < 3); end
      if (o.vld !== 1'(i >= 2)) begin errors++; $display("FAIL bp_valid cyc %0d got %b want %b", i, o.vld, i >= 2); end
      if (i >= 2) begin
        checks++;
        if (o.data !== rom_mem[0]) begin errors++; $display("FAIL bp_hold cyc %0d got %h want %h", i, o.data, rom_mem[0]); end
      end
    end
    checks++;
    if (accepts != 3) begin errors++; $display("FAIL bp_accepts got %0d want 3", accepts); end
    for (int j = 0; j < 4; j++) begin
      cycle(1'b0, 32'h0, 1'b1, o, e);
      checks += 2;
      if (o.vld !== 1'(j < 3)) begin errors++; $display("FAIL bp_drain_valid cyc %0d got %b want %b", j, o.vld, j < 3); end
      if (o.rdy !== 1'(j >= 1)) begin errors++; $display("FAIL bp_drain_ready cyc %0d got %b want %b", j, o.rdy, j >= 1); end
      if (j < 3) begin
        checks++;
        if (o.data !== rom_mem[j]) begin errors++; $display("FAIL bp_drain_data cyc %0d got %h want %h", j, o.data, rom_mem[j]); end
      end
    end
  endtask

  task automatic test_faults();
    obs_t        o, e;
    logic [31:0] addrs [3];
    logic [31:0] wdata [3];
    logic        werr  [3];
    addrs[0] = BASE + 32'h2;    wdata[0] = 32'h0;         werr[0] = 1'b1;
    addrs[1] = BASE + 32'h1000; wdata[1] = 32'h0;         werr[1] = 1'b1;
    addrs[2] = BASE + 32'hFFC;  wdata[2] = rom_mem[1023]; werr[2] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cycle(i < 3, (i < 3) ? addrs[i] : 32'h0, 1'b1, o, e);
      checks++;
      if (o.vld !== 1'(i >= 2 && i < 5)) begin errors++; $display("FAIL fault_valid cyc %0d got %b", i, o.vld); end
      if (i >= 2 && i < 5) begin
        checks++;
        if (o.data !== wdata[i-2] || o.err !== werr[i-2])
          begin errors++; $display("FAIL fault_rsp%0d got %h/%b want %h/%b", i - 2, o.data, o.err, wdata[i-2], werr[i-2]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    for (int i = 0; i < 4; i++) cycle(i < 2, BASE + 32'(4 * (i + 3)), 1'b0, o, e);
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b want 1", rsp_valid); end
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", rsp_valid); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b want 0", cmd_ready); end
    if (rsp_data !== 32'h0) begin errors++; $display("FAIL rmid_data got %h want 0", rsp_data); end
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 1'b1, o, e);
      checks += 2;
      if (o.vld !== 1'b0) begin errors++; $display("FAIL rmid_stale cyc %0d got %b want 0", i, o.vld); end
      if (o.rdy !== 1'b1) begin errors++; $display("FAIL rmid_after_ready cyc %0d got %b want 1", i, o.rdy); end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(i == 0, BASE + 32'h1C, 1'b1, o, e);
      checks += 2;
      if (o.vld !== 1'(i == 2)) begin errors++; $display("FAIL rmid_fetch_valid cyc %0d got %b", i, o.vld); end
      if (o.vld !== e.vld) begin errors++; $display("FAIL rmid_model_valid cyc %0d got %b want %b", i, o.vld, e.vld); end
      if (i == 2) begin
        checks++;
        if (o.data !== rom_mem[7] || o.err !== 1'b0)
          begin errors++; $display("FAIL rmid_fetch_data got %h/%b want %h/0", o.data, o.err, rom_mem[7]); end
      end
    end
  endtask

  task automatic test_random();
    obs_t        o, e;
    logic [31:0] a;
    int          r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       a = BASE + 32'(4 * $urandom_range(0, 1023));
      else if (r == 6) a = BASE + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
      else if (r == 7) a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 1023));
      else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 1024));
      else             a = $urandom;
      cycle(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 2) != 0), o, e);
      checks += 4;
      if (o.rdy !== e.rdy)   begin errors++; $display("FAIL rand_ready cyc %0d got %b want %b", i, o.rdy, e.rdy); end
      if (o.vld !== e.vld)   begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", i, o.vld, e.vld); end
      if (o.data !== e.data) begin errors++; $display("FAIL rand_data cyc %0d got %h want %h", i, o.data, e.data); end
      if (o.err !== e.err)   begin errors++; $display("FAIL rand_error cyc %0d got %b want %b", i, o.err, e.err); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    model_reset();
    test_reset();
    for (int i = 0; i < 5; i++) begin
      obs_t o, e;
      cycle(1'b0, 32'h0, 1'b1, o, e);
    end
    test_single();
    test_stream();
    test_backpressure();
    test_faults();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
